// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcode/funct fields, FSM state, ALU-op and mux-select encodings
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25,
                         FN_SLT = 6'h2A;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3, S_MEMWB = 4'd4,
    S_MEMWR = 4'd5, S_REXE = 4'd6, S_RWB = 4'd7, S_BRANCH = 4'd8, S_JUMP = 4'd9,
    S_IEXE = 4'd10, S_IWB = 4'd11
  } state_t;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_SLT = 4'd4, ALU_LUI = 4'd5;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MDR = 2'd1, WD_PC = 2'd2;
  localparam logic [1:0] SRCB_B = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_BR = 2'd3;
  localparam logic [1:0] PC_ALU = 2'd0, PC_OUT = 2'd1, PC_JMP = 2'd2;
  // State following DECODE; FETCH doubles as the "unsupported opcode" marker.
  function automatic state_t op_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEMADR;
      OP_RTYPE: return S_REXE;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_J, OP_JAL: return S_JUMP;
      OP_ADDI, OP_ORI, OP_LUI: return S_IEXE;
      default: return S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath bundle (IR fields, zero flag in; enables/selects out)
// master = controller, slave = datapath. mem_req/mem_ready exist only with MC_STALL_EN.
interface multicycle_ctrl_if #(parameter int STATE_W = 4, parameter int ALUOP_W = 4);
  logic [5:0] opcode, funct;
  logic zero;
  logic pc_we, ir_we, mem_we, i_or_d, rf_we;
  logic [1:0] rf_dst, wd_sel;
  logic alu_srca;
  logic [1:0] alu_srcb;
  logic ext_op;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0] pc_src;
  logic illegal;
  logic [STATE_W-1:0] dbg_state;
`ifdef MC_STALL_EN
  logic mem_ready, mem_req;
`endif
  modport master (
`ifdef MC_STALL_EN
    input mem_ready, output mem_req,
`endif
    input opcode, funct, zero,
    output pc_we, ir_we, mem_we, i_or_d, rf_we, rf_dst, wd_sel, alu_srca, alu_srcb, ext_op,
    output alu_op, pc_src, illegal, dbg_state
  );
  modport slave (
`ifdef MC_STALL_EN
    output mem_ready, input mem_req,
`endif
    output opcode, funct, zero,
    input pc_we, ir_we, mem_we, i_or_d, rf_we, rf_dst, wd_sel, alu_srca, alu_srcb, ext_op,
    input alu_op, pc_src, illegal, dbg_state
  );
endinterface

// File: rtl/multicycle_ctrl_alu_funct_dec.sv
// alu_funct_dec: R-type funct to alu_op mapping with unsupported-funct flag
// funct in, alu_op/bad out (purely combinational)
module alu_funct_dec import mips_ctrl_pkg::*; #(parameter int ALUOP_W = 4) (
  input  logic [5:0]         funct,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               bad
);
  always_comb begin
    alu_op = ALUOP_W'(ALU_ADD);
    bad = 1'b0;
    case (funct)
      FN_ADD: alu_op = ALUOP_W'(ALU_ADD);
      FN_SUB: alu_op = ALUOP_W'(ALU_SUB);
      FN_AND: alu_op = ALUOP_W'(ALU_AND);
      FN_OR:  alu_op = ALUOP_W'(ALU_OR);
      FN_SLT: alu_op = ALUOP_W'(ALU_SLT);
      default: bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing the multicycle MIPS datapath
// clk, rst (async active-low), bus (multicycle_ctrl_if.master). Optional MC_STALL_EN adds memory handshake.
module multicycle_ctrl import mips_ctrl_pkg::*; #(
  parameter int STATE_W = 4,
  parameter int ALUOP_W = 4
) (
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.master bus
);
  state_t state, nxt;
  logic kill, rdy, f_bad;
  logic [ALUOP_W-1:0] f_op;
`ifdef MC_STALL_EN
  assign rdy = bus.mem_ready;
  assign bus.mem_req = rst & (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
`else
  assign rdy = 1'b1;
`endif
  alu_funct_dec #(.ALUOP_W(ALUOP_W)) u_fdec (.funct(bus.funct), .alu_op(f_op), .bad(f_bad));
  always_comb begin
    case (state)
      S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: nxt = op_next(bus.opcode);
      S_MEMADR: nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
      S_REXE:   nxt = S_RWB;
      S_IEXE:   nxt = S_IWB;
      default:  nxt = S_FETCH;
    endcase
  end
  // kill remembers an unsupported funct so RWB does not write the register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      kill <= 1'b0;
    end else begin
      state <= nxt;
      kill <= (state == S_REXE) & f_bad;
    end
  end
  // reset low forces every output to zero regardless of state
  always_comb begin
    bus.pc_we = 1'b0;
    bus.ir_we = 1'b0;
    bus.mem_we = 1'b0;
    bus.i_or_d = 1'b0;
    bus.rf_we = 1'b0;
    bus.rf_dst = DST_RT;
    bus.wd_sel = WD_ALU;
    bus.alu_srca = 1'b0;
    bus.alu_srcb = SRCB_B;
    bus.ext_op = 1'b0;
    bus.alu_op = ALUOP_W'(ALU_ADD);
    bus.pc_src = PC_ALU;
    bus.illegal = 1'b0;
    bus.dbg_state = rst ? STATE_W'(state) : '0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          bus.pc_we = rdy;
          bus.ir_we = rdy;
          bus.alu_srcb = SRCB_4;
        end
        S_DECODE: begin
          bus.alu_srcb = SRCB_BR;
          bus.illegal = op_next(bus.opcode) == S_FETCH;
        end
        S_MEMADR: begin
          bus.alu_srca = 1'b1;
          bus.alu_srcb = SRCB_IMM;
          bus.ext_op = 1'b1;
        end
        S_MEMRD: bus.i_or_d = 1'b1;
        S_MEMWB: begin
          bus.rf_we = 1'b1;
          bus.wd_sel = WD_MDR;
        end
        S_MEMWR: begin
          bus.i_or_d = 1'b1;
          bus.mem_we = 1'b1;
        end
        S_REXE: begin
          bus.alu_srca = 1'b1;
          bus.alu_op = f_op;
          bus.illegal = f_bad;
        end
        S_RWB: begin
          bus.rf_we = !kill;
          bus.rf_dst = DST_RD;
        end
        S_BRANCH: begin
          bus.alu_srca = 1'b1;
          bus.alu_op = ALUOP_W'(ALU_SUB);
          bus.pc_src = PC_OUT;
          bus.pc_we = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
        end
        S_JUMP: begin
          bus.pc_we = 1'b1;
          bus.pc_src = PC_JMP;
          bus.rf_we = bus.opcode == OP_JAL;
          bus.rf_dst = (bus.opcode == OP_JAL) ? DST_RA : DST_RT;
          bus.wd_sel = (bus.opcode == OP_JAL) ? WD_PC : WD_ALU;
        end
        S_IEXE: begin
          bus.alu_srca = 1'b1;
          bus.alu_srcb = SRCB_IMM;
          bus.ext_op = bus.opcode == OP_ADDI;
          bus.alu_op = (bus.opcode == OP_ORI) ? ALUOP_W'(ALU_OR) :
                       (bus.opcode == OP_LUI) ? ALUOP_W'(ALU_LUI) : ALUOP_W'(ALU_ADD);
        end
        S_IWB: bus.rf_we = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked cycle-by-cycle against a behavioural model
module tb_multicycle_ctrl;
  typedef struct packed {
    logic [3:0] st;
    logic pc_we, ir_we, mem_we, i_or_d, rf_we;
    logic [1:0] rf_dst, wd_sel;
    logic srca;
    logic [1:0] srcb;
    logic ext_op;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic illegal, mem_req;
  } vec_t;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  multicycle_ctrl_if #(.STATE_W(4), .ALUOP_W(4)) bus();
  multicycle_ctrl #(.STATE_W(4), .ALUOP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, rfw = 0, mw = 0, ill = 0, pcw = 0, cyc = 0;
  bit chk_en = 0, rdy = 1;
  vec_t exp_v = '0;
`ifdef MC_STALL_EN
  localparam bit STALL = 1;
  assign bus.mem_ready = rdy;
`else
  localparam bit STALL = 0;
`endif
  function automatic vec_t dut_vec();
    vec_t v;
    v = '0;
    v.st = bus.dbg_state;
    v.pc_we = bus.pc_we; v.ir_we = bus.ir_we; v.mem_we = bus.mem_we;
    v.i_or_d = bus.i_or_d; v.rf_we = bus.rf_we; v.rf_dst = bus.rf_dst; v.wd_sel = bus.wd_sel;
    v.srca = bus.alu_srca; v.srcb = bus.alu_srcb; v.ext_op = bus.ext_op; v.alu_op = bus.alu_op;
    v.pc_src = bus.pc_src; v.illegal = bus.illegal;
`ifdef MC_STALL_EN
    v.mem_req = bus.mem_req;
`endif
    return v;
  endfunction
  function automatic int fn_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 0;
      6'h22: return 1;
      6'h24: return 2;
      6'h25: return 3;
      6'h2A: return 4;
      default: return -1;
    endcase
  endfunction
  // Instruction class -> sequence of steps, straight from the latency table
  function automatic int plan(input logic [5:0] op, output int st[5]);
    st = '{0, 1, 0, 0, 0};
    case (op)
      6'h23: begin st = '{0, 1, 2, 3, 4}; return 5; end
      6'h2B: begin st = '{0, 1, 2, 5, 0}; return 4; end
      6'h00: begin st = '{0, 1, 6, 7, 0}; return 4; end
      6'h04, 6'h05: begin st = '{0, 1, 8, 0, 0}; return 3; end
      6'h02, 6'h03: begin st = '{0, 1, 9, 0, 0}; return 3; end
      6'h08, 6'h0D, 6'h0F: begin st = '{0, 1, 10, 11, 0}; return 4; end
      default: return 2;
    endcase
  endfunction
  function automatic vec_t exp_out(input int s, input logic [5:0] op, input logic [5:0] fn,
                                   input bit z, input bit r);
    vec_t v;
    int a;
    v = '0;
    v.st = 4'(s);
    a = fn_alu(fn);
    case (s)
      0: begin v.pc_we = r; v.ir_we = r; v.srcb = 1; v.mem_req = STALL; end
      1: begin
        v.srcb = 3;
        v.illegal = !(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B});
      end
      2: begin v.srca = 1; v.srcb = 2; v.ext_op = 1; end
      3: begin v.i_or_d = 1; v.mem_req = STALL; end
      4: begin v.rf_we = 1; v.wd_sel = 1; end
      5: begin v.i_or_d = 1; v.mem_we = 1; v.mem_req = STALL; end
      6: begin v.srca = 1; v.alu_op = (a < 0) ? 4'd0 : 4'(a); v.illegal = a < 0; end
      7: begin v.rf_we = a >= 0; v.rf_dst = 1; end
      8: begin v.srca = 1; v.alu_op = 1; v.pc_src = 1; v.pc_we = (op == 6'h04) ? z : !z; end
      9: begin
        v.pc_we = 1; v.pc_src = 2;
        if (op == 6'h03) begin v.rf_we = 1; v.rf_dst = 2; v.wd_sel = 2; end
      end
      10: begin
        v.srca = 1; v.srcb = 2;
        v.ext_op = op == 6'h08;
        v.alu_op = (op == 6'h0D) ? 4'd3 : (op == 6'h0F) ? 4'd5 : 4'd0;
      end
      11: v.rf_we = 1;
      default: ;
    endcase
    return v;
  endfunction
  task automatic lit(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask
  // Entered at posedge+1 of a FETCH cycle; leaves at posedge+1 of the next FETCH
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input bit z, input bit rnd,
                     input int force_stall);
    int st[5];
    int n, idx, stl;
    bit mem;
    n = plan(op, st);
    idx = 0; stl = 0;
    bus.opcode = op; bus.funct = fn; bus.zero = z;
    rfw = 0; mw = 0; ill = 0; pcw = 0; cyc = 0;
    while (idx < n) begin
      mem = st[idx] inside {0, 3, 5};
      rdy = !(STALL && mem && ((st[idx] == 5 && stl < force_stall) ||
                               (rnd && stl < 3 && $urandom_range(0, 2) == 0)));
      exp_v = exp_out(st[idx], op, fn, z, rdy);
      chk_en = 1;
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin idx++; stl = 0; end else stl++;
    end
    chk_en = 0;
    rdy = 1;
  endtask
  initial begin
    vec_t a;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        a = dut_vec();
        checks++;
        if (a !== exp_v) begin
          errors++;
          $display("FAIL step%0d outputs: got %h expected %h", exp_v.st, a, exp_v);
        end
        rfw += int'(a.rf_we); mw += int'(a.mem_we); ill += int'(a.illegal); pcw += int'(a.pc_we);
      end
    end
  end
  initial begin
    logic [5:0] ops[11];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 0;
    #3;
    lit("reset_outputs", int'(dut_vec()), 0);
    lit("reset_state", int'(bus.dbg_state), 0);
    @(posedge clk); #1;
    rst = 1;
    run(6'h23, 0, 0, 0, 0);
    lit("lw_latency", cyc, 5); lit("lw_rf_we_cycles", rfw, 1);
    run(6'h2B, 0, 0, 0, 0);
    lit("sw_latency", cyc, 4); lit("sw_mem_we_cycles", mw, 1);
    run(6'h04, 0, 1, 0, 0); lit("beq_taken_pc_we", pcw, 2); lit("beq_latency", cyc, 3);
    run(6'h04, 0, 0, 0, 0); lit("beq_not_taken_pc_we", pcw, 1);
    run(6'h05, 0, 1, 0, 0); lit("bne_z1_pc_we", pcw, 1);
    run(6'h05, 0, 0, 0, 0); lit("bne_z0_pc_we", pcw, 2);
    run(6'h03, 0, 0, 0, 0); lit("jal_latency", cyc, 3); lit("jal_rf_we", rfw, 1);
    run(6'h3F, 0, 0, 0, 0);
    lit("illegal_latency", cyc, 2); lit("illegal_pulses", ill, 1);
    lit("illegal_rf_we", rfw, 0); lit("illegal_mem_we", mw, 0);
    run(6'h00, 6'h3F, 0, 0, 0);
    lit("badfunct_pulses", ill, 1); lit("badfunct_rf_we", rfw, 0); lit("badfunct_latency", cyc, 4);
    run(6'h00, 6'h2A, 0, 0, 0); lit("rtype_latency", cyc, 4); lit("rtype_rf_we", rfw, 1);
    run(6'h0F, 0, 0, 0, 0); lit("lui_latency", cyc, 4);
    bus.opcode = 6'h00; bus.funct = 6'h22;
    @(posedge clk); #1;
    @(posedge clk); #1;
    lit("pre_abort_state", int'(bus.dbg_state), 6);
    rst = 0;
    #1;
    lit("abort_outputs", int'(dut_vec()), 0);
    #19;
    lit("abort_held_outputs", int'(dut_vec()), 0);
    rst = 1;
    run(6'h08, 0, 0, 0, 0); lit("after_abort_latency", cyc, 4);
`ifdef MC_STALL_EN
    run(6'h2B, 0, 0, 0, 3);
    lit("stall_sw_latency", cyc, 7); lit("stall_sw_mem_we_cycles", mw, 4);
`endif
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
      run(op, fn, 1'($urandom_range(0, 1)), 1, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style FSM control unit for the planned multicycle MIPS datapath; replaces the single-cycle combinational decoder.
- Sequences a shared memory, ALU and register file over Fetch, Decode, Execute, Memory and Writeback steps.
- Inputs: instruction fields from the IR and the ALU zero flag.
- Outputs: all write enables and mux selects for PC, IR, memory, register file and ALU.

Parameters:
- STATE_W, 4, state register width; also the width of the dbg_state port.
- ALUOP_W, 4, width of alu_op.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (rs-rt in BRANCH)
- mem_ready  in  1  memory done; present only with MC_STALL_EN
- mem_req  out  1  memory access strobe; present only with MC_STALL_EN
- pc_we  out  1  PC write
- ir_we  out  1  IR write
- mem_we  out  1  memory write
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- rf_we  out  1  register file write
- rf_dst  out  2  write register: 0=rt, 1=rd, 2=$31
- wd_sel  out  2  write data: 0=ALUOut, 1=MDR, 2=PC
- alu_srca  out  1  0=PC, 1=A(rs)
- alu_srcb  out  2  0=B, 1=const 4, 2=ext imm, 3=sext imm<<2
- ext_op  out  1  1=sign-extend, 0=zero-extend
- alu_op  out  ALUOP_W  ALU operation code
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- dbg_state  out  STATE_W  current state

Behaviour:
- Supported instructions: R-type add/sub/and/or/slt; lw, sw, beq, bne, addi, ori, lui, j, jal.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXE=6, RWB=7, BRANCH=8, JUMP=9, IEXE=10, IWB=11. Encodings 12-15 go to FETCH.
- Reset: while rst=0, state=FETCH and every output is 0, overriding decode. The first rising edge after rst rises performs the fetch. Reset asserted mid-instruction aborts it with no further writes.
- FETCH: ir_we=1, pc_we=1, i_or_d=0, alu_srca=0, alu_srcb=1, alu_op=ADD, pc_src=0. Next state is DECODE.
- DECODE: ALUOut gets the branch target (alu_srca=0, alu_srcb=3, ADD). Next state by opcode:
  - lw/sw go to MEMADR.
  - R-type goes to REXE.
  - beq/bne go to BRANCH.
  - j/jal go to JUMP.
  - addi/ori/lui go to IEXE.
  - Anything else: illegal=1 this cycle, next state FETCH.
- MEMADR: srca=1, srcb=2, ext_op=1, ADD. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: i_or_d=1. Next state MEMWB.
- MEMWB: rf_we=1, rf_dst=0, wd_sel=1. Next state FETCH.
- MEMWR: i_or_d=1, mem_we=1. Next state FETCH.
- REXE: srca=1, srcb=0, alu_op from funct. An unknown funct raises illegal, and the FSM still proceeds to RWB with rf_we suppressed. Next state RWB.
- RWB: rf_we=1, rf_dst=1, wd_sel=0. Next state FETCH.
- BRANCH: srca=1, srcb=0, SUB, pc_src=1. pc_we is set as follows:
  - beq: pc_we=zero.
  - bne: pc_we=!zero.
  - Next state FETCH.
- JUMP: pc_we=1, pc_src=2.
  - jal additionally: rf_we=1, rf_dst=2, wd_sel=2 (PC already holds PC+4).
  - Next state FETCH.
- IEXE: srca=1, srcb=2.
  - addi: ext_op=1, ADD.
  - ori: ext_op=0, OR.
  - lui: ext_op=0, LUI.
  - Next state IWB.
- IWB: rf_we=1, rf_dst=0, wd_sel=0. Next state FETCH.
- Latency in cycles (no stall): beq/bne/j/jal 3; R-type, sw and immediates 4; lw 5.
- Outputs not listed for a state are 0.

Optional Feature:
- MC_STALL_EN defined:
  - mem_req=1 in FETCH, MEMRD and MEMWR.
  - The FSM holds in those states while mem_ready=0.
  - In FETCH, pc_we and ir_we are gated by mem_ready.
  - In MEMWR, mem_we stays high until the cycle mem_ready=1.
  - If mem_ready is already 1 on entry, timing equals the non-stall build.
- MC_STALL_EN undefined: the mem_req and mem_ready ports are absent, and every memory state lasts one cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct localparams;
  - state encodings;
  - ALU op codes (ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5);
  - mux select encodings.
- The datapath ALU and decoders import the same package.
- Optional sub-module alu_funct_dec: combinational funct-to-alu_op mapping plus the illegal-funct flag.

Test Plan:
- Reset pulse mid-REXE (drive rst=0 for 20 ns): all outputs 0 immediately; after release, dbg_state sequences 0,1,...
- lw (opcode 0x23) -> states 0,1,2,3,4,0. rf_we=1 only in state 4, with wd_sel=1 and i_or_d=1 in state 3.
- beq (0x04) with zero=1 -> pc_we=1, pc_src=1 in BRANCH; repeat with zero=0 -> pc_we=0. Check bne the same way, inverted.
- jal (0x03) -> JUMP asserts pc_we=1, pc_src=2, rf_we=1, rf_dst=2, wd_sel=2; 3 cycles total.
- opcode 0x3F -> illegal=1 for one cycle in DECODE, then FETCH, with no rf_we or mem_we ever asserted.
- MC_STALL_EN with mem_ready low for 3 cycles during sw -> stays in MEMWR for 4 cycles, mem_we high throughout, then FETCH.
